// File: rtl/mp_out_fifo_if.sv
// Output-FIFO bus: core push side plus consumer valid/ready side and status.
// Latency: wires only; no storage in the interface.
// Backpressure: consumer stalls with Rd_Ready=0; the core side cannot be stalled.
interface mp_out_fifo_if #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
);
    logic          Out_WE;
    logic [15:0]   Design_OUT;
    logic          Rd_Ready;
    logic          Rd_Valid;
    logic [15:0]   Rd_Data;
    logic          Full;
    logic          Empty;
    logic [AW:0]   Count;
    logic          Overflow;
    logic [7:0]    Drop_Cnt;

    modport master (
        output Out_WE, Design_OUT, Rd_Ready,
        input  Rd_Valid, Rd_Data, Full, Empty, Count, Overflow, Drop_Cnt
    );

    modport slave (
        input  Out_WE, Design_OUT, Rd_Ready,
        output Rd_Valid, Rd_Data, Full, Empty, Count, Overflow, Drop_Cnt
    );
endinterface

// File: rtl/mp_out_fifo.sv
// Circular-buffer output queue between the MP core and a slower consumer.
// Latency: push at edge k is visible at the head after edge k; pop shows next head after edge k.
// Backpressure: consumer via Rd_Ready; pushes into a full queue without a pop are dropped and counted.
module mp_out_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        Clk,
    input  logic        Rst,
    mp_out_fifo_if.slave bus
);
    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [7:0]    r_drop_cnt;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = !w_empty && bus.Rd_Ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign w_push  = bus.Out_WE && (!w_full || w_pop);
    assign w_drop  = bus.Out_WE && !w_push;

    always_ff @(posedge Clk) begin
        if (w_push && !Rst) begin
            r_mem[r_wp] <= bus.Design_OUT;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.Rd_Valid = !w_empty;
    assign bus.Rd_Data  = w_empty ? 16'h0000 : r_mem[r_rp];
    assign bus.Full     = w_full;
    assign bus.Empty    = w_empty;
    assign bus.Count    = r_count;
    assign bus.Overflow = r_overflow;
    assign bus.Drop_Cnt = r_drop_cnt;
endmodule

// File: tb/tb_mp_out_fifo.sv
module tb_mp_out_fifo;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    mp_out_fifo_if #(.DEPTH(DEPTH)) bus ();

    mp_out_fifo #(.DEPTH(DEPTH)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural reference: a plain queue of words plus sticky drop bookkeeping.
    logic [15:0] mq[$];
    bit          m_ovf;
    int          m_drop;

    typedef struct {
        bit          rst;
        bit          we;
        logic [15:0] d;
        bit          rdy;
        int          e_count;
        bit          e_valid;
        logic [15:0] e_data;
        bit          e_full;
        bit          e_ovf;
        int          e_drop;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step(input bit r, input bit we, input logic [15:0] d, input bit rdy);
        bit pop;
        bit acc;
        if (r) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            pop = (mq.size() > 0) && rdy;
            acc = we && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(d);
            else if (we) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
    endtask

    task automatic compare_model();
        check("model_count", 32'(bus.Count), mq.size());
        check("model_valid", 32'(bus.Rd_Valid), 32'(mq.size() > 0));
        check("model_data", 32'(bus.Rd_Data), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
        check("model_full", 32'(bus.Full), 32'(mq.size() == DEPTH));
        check("model_empty", 32'(bus.Empty), 32'(mq.size() == 0));
        check("model_ovf", 32'(bus.Overflow), 32'(m_ovf));
        check("model_drop", 32'(bus.Drop_Cnt), m_drop);
    endtask

    task automatic cycle(input bit r, input bit we, input logic [15:0] d, input bit rdy);
        rst            = r;
        bus.Out_WE     = we;
        bus.Design_OUT = d;
        bus.Rd_Ready   = rdy;
        @(posedge clk);
        model_step(r, we, d, rdy);
        #1;
        compare_model();
    endtask

    task automatic add(input bit r, input bit we, input logic [15:0] d, input bit rdy,
                       input int c, input bit v, input logic [15:0] ed, input bit f,
                       input bit o, input int dr);
        vec_t x;
        x.rst = r; x.we = we; x.d = d; x.rdy = rdy;
        x.e_count = c; x.e_valid = v; x.e_data = ed; x.e_full = f; x.e_ovf = o; x.e_drop = dr;
        vt.push_back(x);
    endtask

    task automatic fill_to(input int n, input int base);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 16'(base + i), 1'b0);
    endtask

    // The head word must hold while the consumer stalls.
    assert property (@(posedge clk) disable iff (rst)
                     (bus.Rd_Valid && !bus.Rd_Ready) |=> $stable(bus.Rd_Data));

    initial begin
        rst            = 1'b1;
        bus.Out_WE     = 1'b0;
        bus.Design_OUT = 16'h0;
        bus.Rd_Ready   = 1'b0;

        // Reset, single word, then fill/overflow/drain with hand-derived expectations.
        add(1, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0);
        add(1, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0);
        add(0, 1, 16'hA5A5, 0, 1, 1, 16'hA5A5, 0, 0, 0);
        add(0, 0, 16'h0, 1, 0, 0, 16'h0, 0, 0, 0);
        for (int i = 1; i <= 10; i++)
            add(0, 1, 16'(i), 0, (i < 8) ? i : 8, 1, 16'h1, i >= 8, i >= 9, (i > 8) ? i - 8 : 0);
        for (int j = 1; j <= 8; j++)
            add(0, 0, 16'h0, 1, 8 - j, j < 8, (j < 8) ? 16'(j + 1) : 16'h0, 0, 1, 2);

        for (int k = 0; k < vt.size(); k++) begin
            cycle(vt[k].rst, vt[k].we, vt[k].d, vt[k].rdy);
            check($sformatf("tbl%0d_count", k), 32'(bus.Count), vt[k].e_count);
            check($sformatf("tbl%0d_valid", k), 32'(bus.Rd_Valid), 32'(vt[k].e_valid));
            check($sformatf("tbl%0d_data", k), 32'(bus.Rd_Data), 32'(vt[k].e_data));
            check($sformatf("tbl%0d_full", k), 32'(bus.Full), 32'(vt[k].e_full));
            check($sformatf("tbl%0d_ovf", k), 32'(bus.Overflow), 32'(vt[k].e_ovf));
            check($sformatf("tbl%0d_drop", k), 32'(bus.Drop_Cnt), vt[k].e_drop);
        end

        // Simultaneous push and pop while full.
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        fill_to(8, 1);
        cycle(1'b0, 1'b1, 16'd9, 1'b1);
        check("fullpp_count", 32'(bus.Count), 8);
        check("fullpp_drop", 32'(bus.Drop_Cnt), 0);
        check("fullpp_ovf", 32'(bus.Overflow), 0);
        for (int k = 2; k <= 9; k++) begin
            check("fullpp_drain_word", 32'(bus.Rd_Data), k);
            cycle(1'b0, 1'b0, 16'h0, 1'b1);
        end
        check("fullpp_empty", 32'(bus.Empty), 1);

        // Wrap-around streaming at one push and one pop per cycle.
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (i > 0) check("stream_word", 32'(bus.Rd_Data), i - 1);
            cycle(1'b0, 1'b1, 16'(i), 1'b1);
            check("stream_count", 32'(bus.Count), 1);
        end
        check("stream_last", 32'(bus.Rd_Data), 39);
        check("stream_ovf", 32'(bus.Overflow), 0);

        // Reset wins over a simultaneous push and pop.
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        fill_to(5, 16'h100);
        cycle(1'b1, 1'b1, 16'hDEAD, 1'b1);
        check("midrst_count", 32'(bus.Count), 0);
        check("midrst_ovf", 32'(bus.Overflow), 0);
        check("midrst_valid", 32'(bus.Rd_Valid), 0);
        cycle(1'b0, 1'b1, 16'h1234, 1'b0);
        check("midrst_head", 32'(bus.Rd_Data), 32'h1234);
        check("midrst_count1", 32'(bus.Count), 1);

        // Drop counter saturation.
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        fill_to(8, 16'h40);
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 16'(16'h800 + i), 1'b0);
        check("sat_drop", 32'(bus.Drop_Cnt), 255);
        check("sat_ovf", 32'(bus.Overflow), 1);
        check("sat_head", 32'(bus.Rd_Data), 32'h40);

        // Randomized traffic against the reference queue.
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
                  16'($urandom), $urandom_range(0, 1) == 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mp_out_fifo.md
# mp_out_fifo

Output buffer that sits directly downstream of the MP core. Captures each 16-bit `Design_OUT` word on a write strobe from the core and queues it for a slower consumer (UART/LED/host bridge) over a valid/ready handshake. Overflow is flagged, never silently hidden, so output-port programs can be checked end to end.

## Interface

Parameters:
- `DEPTH`, 8: number of 16-bit entries. Must be a power of two, 2..256.
- `AW`, log2(`DEPTH`): pointer width.

Ports:
- `Clk`, in, 1: single clock. All state changes on the rising edge.
- `Rst`, in, 1: reset. Synchronous, active-high.
- `Out_WE`, in, 1: push strobe from the MP core, one per OUT instruction.
- `Design_OUT`, in, 16: data word from the MP core, sampled when `Out_WE`=1.
- `Rd_Ready`, in, 1: consumer accepts the head word.
- `Rd_Valid`, out, 1: head word is available.
- `Rd_Data`, out, 16: head word. Forced to 0 when `Rd_Valid`=0.
- `Full`, out, 1: count equals `DEPTH`.
- `Empty`, out, 1: count equals 0.
- `Count`, out, AW+1: current occupancy, 0..`DEPTH`.
- `Overflow`, out, 1: sticky. Set when a push is dropped.
- `Drop_Cnt`, out, 8: number of dropped pushes. Saturates at 255.

## Operation

- Storage is a circular buffer `mem[DEPTH]` with a write pointer (`wp`) and a read pointer (`rp`), each AW bits wide. Pointers wrap modulo `DEPTH`. Occupancy is tracked in `Count`.
- **Push**: when `Out_WE`=1 and the push is accepted, write `mem[wp]` = `Design_OUT`, then `wp` = `wp`+1.
- **Pop**: occurs when `Rd_Valid`=1 and `Rd_Ready`=1. Then `rp` = `rp`+1.
- **Push acceptance**:
  - Accepted when `Full`=0.
  - Accepted when `Full`=1 and a pop occurs in the same cycle. `Count` is unchanged.
  - Otherwise the push is dropped: `Overflow` is set to 1 and `Drop_Cnt` increments, saturating at 255. `mem`, `wp` and `Count` are unchanged.
- **Empty with push and `Rd_Ready` in the same cycle**: push only. No pop, because `Rd_Valid` was 0.
- **Count update**: +1 on push only, −1 on pop only, unchanged on both or neither.
- **Flags**: `Full`, `Empty` and `Rd_Valid` are derived from registered `Count`.
  - `Rd_Valid` = !`Empty`.
  - `Rd_Data` = `Rd_Valid` ? `mem[rp]` : 16'h0000.
- **Clearing**: `Overflow` and `Drop_Cnt` are cleared only by `Rst`.
- **Reset values**:
  - `wp`=0, `rp`=0, `Count`=0.
  - `Empty`=1, `Full`=0, `Rd_Valid`=0, `Rd_Data`=0.
  - `Overflow`=0, `Drop_Cnt`=0.
  - `mem` contents are not cleared.
- **Reset mid-operation**: `Rst` wins over a simultaneous push or pop. All queued words are discarded. The first push after `Rst` deasserts lands in `mem[0]`.
- **Assertion for verification**: `Rd_Data` must not change while `Rd_Valid`=1 and `Rd_Ready`=0. A push must never alter the head entry.

## Timing

- **Push-to-valid latency**: 1 cycle. A push at edge k makes `Rd_Valid`=1 and `Rd_Data` = the pushed word after edge k.
- **Throughput**: one push and one pop per cycle sustained, with no bubble at any occupancy.
- **Pop-to-next-head**: a pop at edge k presents the next entry on `Rd_Data` after edge k.
- **Flag timing**:
  - `Full` asserts after the edge that makes `Count`=`DEPTH`.
  - `Full` deasserts after the first pop-only edge.
  - `Overflow` and `Drop_Cnt` update on the same edge as the dropped push.
- **Consumer rule**: `Rd_Ready` may be asserted regardless of `Rd_Valid`. It has no effect while `Rd_Valid`=0.
- **Core rule**: the MP core is not stalled. `Out_WE` may assert on any cycle, including back-to-back.

## Test plan

- **Reset, then single word**: `Rst`=1 for 2 cycles, then push 16'hA5A5 with `Rd_Ready`=0. Required: after that edge, `Rd_Valid`=1, `Rd_Data`=A5A5, `Count`=1. Then set `Rd_Ready`=1 for 1 cycle. Required: `Empty`=1, `Rd_Data`=0.
- **Fill and overflow (`DEPTH`=8)**: push 1..10 with `Rd_Ready`=0. Required: `Full`=1 after the 8th push, `Overflow`=1, `Drop_Cnt`=2. Then drain. Required: words read out are exactly 1..8 in order.
- **Simultaneous push and pop at full**: queue full with 1..8. Push 9 with `Rd_Ready`=1. Required: 1 is popped, `Count` stays 8, no drop. A subsequent drain yields 2..9.
- **Wrap-around streaming**: 40 cycles of continuous push with `Rd_Ready`=1, data 0..39. Required: `Count` holds at 1, output sequence is 0..39 with no gaps, `Overflow`=0.
- **Reset mid-operation**: with 5 words queued, assert `Rst` for 1 cycle while `Out_WE`=1 and `Rd_Ready`=1. Required: after the edge, `Count`=0, `Overflow`=0, and the next push of 16'h1234 appears as the head.
- **`Drop_Cnt` saturation**: with the queue full, issue 300 pushes without popping. Required: `Drop_Cnt`=255 and `Overflow`=1.
